// File: rtl/derrida_accumulator.sv
// Derrida accumulator: captures a GRN transition table, bins output Hamming
// distance over every state pair by input Hamming distance, then streams N records.
module derrida_accumulator #(
  parameter int unsigned N     = 5,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             input_data_valid,
  input  logic [N-1:0]     input_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_hamming,
  output logic [ACC_W-1:0] out_count,
  output logic [ACC_W-1:0] out_sum,
  output logic             done,
  output logic             err
);

  localparam int unsigned DEPTH = 1 << N;

  typedef enum logic [1:0] {ST_CAPTURE, ST_COMPUTE, ST_DRAIN, ST_DONE} state_t;

  state_t             state, state_nxt;
  logic [N-1:0]       wr_cnt;
  logic [N-1:0]       i_idx, j_idx;
  logic [N-1:0]       tbl [DEPTH];
  logic [ACC_W-1:0]   cnt [N];
  logic [ACC_W-1:0]   sum [N];
  logic [N-1:0]       hin, hout;
  logic               last_beat, last_pair, accept;
  logic [N-1:0]       rec_sel;
  logic [ACC_W-1:0]   rec_cnt, rec_sum;

  function automatic logic [N-1:0] popcount(input logic [N-1:0] v);
    logic [N-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) c = c + N'(v[k]);
    return c;
  endfunction

  // Pair distances and phase-boundary strobes
  always_comb begin
    hin       = popcount(i_idx ^ j_idx);
    hout      = popcount(tbl[i_idx] ^ tbl[j_idx]);
    last_beat = (state == ST_CAPTURE) && input_data_valid && (wr_cnt == N'(DEPTH - 1));
    last_pair = (state == ST_COMPUTE) && (i_idx == N'(DEPTH - 2));
    accept    = (state == ST_DRAIN) && out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CAPTURE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CAPTURE: if (last_beat) state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (last_pair) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (accept && (out_hamming == N'(N))) state_nxt = ST_DONE;
      default:    state_nxt = ST_DONE;
    endcase
  end

  // Next record to present; on the final pair the bin being updated is bypassed in
  always_comb begin
    rec_sel = (state == ST_COMPUTE) ? N'(1) : out_hamming + N'(1);
    rec_cnt = '0;
    rec_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (rec_sel == N'(k + 1)) begin
        rec_cnt = cnt[k];
        rec_sum = sum[k];
        if ((state == ST_COMPUTE) && (hin == N'(k + 1))) begin
          rec_cnt = cnt[k] + ACC_W'(1);
          rec_sum = sum[k] + ACC_W'(hout);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_CAPTURE) && input_data_valid) tbl[wr_cnt] <= input_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt      <= '0;
      i_idx       <= '0;
      j_idx       <= '0;
      out_valid   <= 1'b0;
      out_hamming <= '0;
      out_count   <= '0;
      out_sum     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      for (int k = 0; k < N; k++) begin
        cnt[k] <= '0;
        sum[k] <= '0;
      end
    end else begin
      if ((state == ST_CAPTURE) && input_data_valid) wr_cnt <= wr_cnt + N'(1);
      if (input_data_valid && (state != ST_CAPTURE)) err <= 1'b1;

      // Pair walk: j sweeps i+1..DEPTH-1, then i advances
      if (last_beat) begin
        i_idx <= '0;
        j_idx <= N'(1);
      end else if ((state == ST_COMPUTE) && !last_pair) begin
        if (j_idx == N'(DEPTH - 1)) begin
          i_idx <= i_idx + N'(1);
          j_idx <= i_idx + N'(2);
        end else begin
          j_idx <= j_idx + N'(1);
        end
      end

      if (state == ST_COMPUTE) begin
        for (int k = 0; k < N; k++) begin
          if (hin == N'(k + 1)) begin
            cnt[k] <= cnt[k] + ACC_W'(1);
            sum[k] <= sum[k] + ACC_W'(hout);
          end
        end
      end

      if (last_pair) begin
        out_valid   <= 1'b1;
        out_hamming <= N'(1);
        out_count   <= rec_cnt;
        out_sum     <= rec_sum;
      end else if (accept) begin
        if (out_hamming == N'(N)) begin
          out_valid <= 1'b0;
          done      <= 1'b1;
        end else begin
          out_hamming <= rec_sel;
          out_count   <= rec_cnt;
          out_sum     <= rec_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_derrida_accumulator.sv
// Scoreboard bench for derrida_accumulator: directed tables with hand-computed
// histograms, backpressure, error injection and asynchronous reset mid-run.
module tb_derrida_accumulator;

  localparam int unsigned N     = 5;
  localparam int unsigned ACC_W = 16;

  localparam int K_IDENT = 0;
  localparam int K_CONST = 1;
  localparam int K_COMPL = 2;
  localparam int K_LOBIT = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             input_data_valid;
  logic [N-1:0]     input_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_hamming;
  logic [ACC_W-1:0] out_count;
  logic [ACC_W-1:0] out_sum;
  logic             done;
  logic             err;

  typedef struct {
    int d;
    int cnt;
    int sum;
  } rec_t;

  rec_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  derrida_accumulator #(.N(N), .ACC_W(ACC_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_data_valid (input_data_valid),
    .input_data       (input_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_hamming      (out_hamming),
    .out_count        (out_count),
    .out_sum          (out_sum),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Hand-derived histograms: count(d) = 16*C(5,d)
  function automatic int exp_cnt(input int d);
    case (d)
      1: return 80;  2: return 160; 3: return 160; 4: return 80; default: return 16;
    endcase
  endfunction

  function automatic int exp_sum(input int kind, input int d);
    int id_s[5];
    int lo_s[5];
    id_s = '{80, 320, 480, 320, 80};
    lo_s = '{16, 64, 96, 64, 16};
    case (kind)
      K_CONST: return 0;
      K_LOBIT: return lo_s[d-1];
      default: return id_s[d-1];
    endcase
  endfunction

  function automatic logic [N-1:0] f_of(input int kind, input int s);
    logic [N-1:0] v;
    v = N'(s);
    case (kind)
      K_CONST: return '0;
      K_COMPL: return ~v;
      K_LOBIT: return {{(N-1){1'b0}}, v[0]};
      default: return v;
    endcase
  endfunction

  task automatic push_recs(input int kind);
    rec_t r;
    for (int d = 1; d <= 5; d++) begin
      r.d = d; r.cnt = exp_cnt(d); r.sum = exp_sum(kind, d);
      q.push_back(r);
    end
  endtask

  task automatic feed(input int kind, input int max_gap);
    for (int s = 0; s < 32; s++) begin
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gaps; g++) begin
        input_data_valid = 1'b0;
        @(posedge clk); #1;
      end
      input_data_valid = 1'b1;
      input_data       = f_of(kind, s);
      @(posedge clk); #1;
    end
    input_data_valid = 1'b0;
  endtask

  task automatic wait_compute(input string name);
    int n = 0;
    while (!out_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_compute_cycles"}, n, 496);
  endtask

  // With out_ready high, records d=1..5 take five handshakes; done follows the last
  task automatic drain_fast(input string name);
    repeat (4) begin @(posedge clk); #1; end
    chk({name, "_last_hamming"}, out_hamming, 5);
    chk({name, "_done_early"}, done, 0);
    @(posedge clk); #1;
    chk({name, "_done"}, done, 1);
    chk({name, "_valid_after_done"}, out_valid, 0);
  endtask

  task automatic reset_async(input string name);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk({name, "_rst_valid"}, out_valid, 0);
    chk({name, "_rst_fields"}, {out_hamming, out_count, out_sum}, 0);
    chk({name, "_rst_done_err"}, {done, err}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic stimulus();
    int n;
    // Identity, back-to-back
    push_recs(K_IDENT);
    feed(K_IDENT, 0);
    wait_compute("ident");
    drain_fast("ident");
    chk("ident_err", err, 0);

    // Constant table
    reset_async("const");
    push_recs(K_CONST);
    feed(K_CONST, 0);
    wait_compute("const");
    drain_fast("const");

    // Complement with random input gaps
    reset_async("compl");
    push_recs(K_COMPL);
    feed(K_COMPL, 3);
    n = 0;
    while (!out_valid && n < 3000) begin @(posedge clk); #1; n++; end
    chk("compl_reached_drain", out_valid, 1);
    drain_fast("compl");

    // Low-bit table with backpressure on d=2 and an illegal beat during DRAIN
    reset_async("bp");
    push_recs(K_LOBIT);
    out_ready = 1'b0;
    feed(K_LOBIT, 0);
    wait_compute("bp");
    @(posedge clk); #1;
    chk("bp_hold_d1", out_hamming, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      chk("bp_hold_hamming", out_hamming, 2);
      chk("bp_hold_count", out_count, 160);
      chk("bp_hold_sum", out_sum, 64);
      chk("bp_hold_valid", out_valid, 1);
      input_data_valid = (c == 3);
      input_data       = 5'h1f;
      @(posedge clk); #1;
      input_data_valid = 1'b0;
    end
    chk("bp_err", err, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_hamming", out_hamming, 3);
    chk("bp_next_valid", out_valid, 1);
    n = 0;
    while (!done && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_done", done, 1);
    chk("bp_err_sticky", err, 1);

    // Reset 200 cycles into COMPUTE, then rerun identity
    reset_async("mid0");
    feed(K_IDENT, 0);
    repeat (200) begin @(posedge clk); #1; end
    chk("mid_in_compute", out_valid, 0);
    reset_async("mid");
    push_recs(K_IDENT);
    feed(K_IDENT, 0);
    wait_compute("rerun");
    drain_fast("rerun");
    chk("rerun_err", err, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every accepted record against the scoreboard head
  task automatic monitor();
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_record", out_hamming, 0);
        end else begin
          r = q.pop_front();
          chk("rec_hamming", out_hamming, r.d);
          chk("rec_count", out_count, r.cnt);
          chk("rec_sum", out_sum, r.sum);
        end
      end
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    input_data_valid = 1'b0;
    input_data       = '0;
    out_ready        = 1'b1;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_fields", {out_hamming, out_count, out_sum}, 0);
    chk("reset_done_err", {done, err}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    fork
      stimulus();
      monitor();
    join_any
    disable fork;
    chk("records_outstanding", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
